// File: rtl/ov7670_frame_writer_if.sv
// Bundle between the OV7670 parallel bus and the frame-RAM write port.
// The master side is the camera/RAM world; the slave side is the frame writer.
interface ov7670_frame_writer_if #(
   parameter int ADDR_W = 19
);
   logic              vsync;
   logic              href;
   logic [7:0]        d;
   logic [ADDR_W-1:0] addr;
   logic [11:0]       dout;
   logic              we;
   logic              frame_done;
   logic              line_err;
   logic [7:0]        frame_cnt;

   modport master (
      output vsync, href, d,
      input  addr, dout, we, frame_done, line_err, frame_cnt
   );

   modport slave (
      input  vsync, href, d,
      output addr, dout, we, frame_done, line_err, frame_cnt
   );
endinterface

// File: rtl/ov7670_frame_writer.sv
// OV7670 capture stage: frames on VSYNC/HREF, pairs RGB565 bytes into RGB444
// pixels and writes them row-major into the frame RAM. Tracks bad line lengths
// per frame and counts completed frames. Everything runs on the pixel clock.
module ov7670_frame_writer #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int ADDR_W   = 19
) (
   input logic                  pclk,
   input logic                  rst,
   ov7670_frame_writer_if.slave bus
);
   localparam int COL_W = $clog2(H_ACTIVE + 1);
   localparam int ROW_W = $clog2(V_ACTIVE + 1);
   localparam logic [COL_W-1:0]  H_LIM  = COL_W'(H_ACTIVE);
   localparam logic [ROW_W-1:0]  V_LIM  = ROW_W'(V_ACTIVE);
   localparam logic [ROW_W-1:0]  V_LAST = ROW_W'(V_ACTIVE - 1);
   localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

   typedef enum logic [1:0] {SYNC, BLANK, ACTIVE} state_t;

   state_t            state;
   logic              vsync_q, vsync_qq;
   logic              href_q, href_qq;
   logic [7:0]        d_q;
   logic              phase;
   logic [6:0]        hi;          // {R[3:0], G[3:1]} from the first byte
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [ADDR_W-1:0] row_base;    // row*H_ACTIVE, built by accumulation
   logic [ADDR_W-1:0] wr_addr;
   logic [11:0]       wr_data;
   logic              wr_en;
   logic              done;
   logic              err;
   logic [7:0]        frames;

   logic              vsync_rise, vsync_fall, href_fall, pixel_ok;
   logic [ADDR_W-1:0] pix_addr;

   assign vsync_rise = vsync_q & ~vsync_qq;
   assign vsync_fall = ~vsync_q & vsync_qq;
   assign href_fall  = ~href_q & href_qq;
   assign pixel_ok   = (col < H_LIM) && (row < V_LIM);
   // Only evaluated when pixel_ok holds, so it never exceeds H*V-1.
   assign pix_addr   = row_base + ADDR_W'(col);

   assign bus.addr       = wr_addr;
   assign bus.dout       = wr_data;
   assign bus.we         = wr_en;
   assign bus.frame_done = done;
   assign bus.line_err   = err;
   assign bus.frame_cnt  = frames;

   // Register the camera pins once, plus a second stage for edge detection.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         vsync_q  <= 1'b0;
         vsync_qq <= 1'b0;
         href_q   <= 1'b0;
         href_qq  <= 1'b0;
         d_q      <= 8'd0;
      end else begin
         vsync_q  <= bus.vsync;
         vsync_qq <= vsync_q;
         href_q   <= bus.href;
         href_qq  <= href_q;
         d_q      <= bus.d;
      end
   end

   // Frame FSM with byte pairing, address generation and statistics.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state    <= SYNC;
         phase    <= 1'b0;
         hi       <= 7'd0;
         col      <= '0;
         row      <= '0;
         row_base <= '0;
         wr_addr  <= '0;
         wr_data  <= 12'd0;
         wr_en    <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         frames   <= 8'd0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            // After reset wait for blanking so a partial frame is never captured.
            SYNC: begin
               if (vsync_q) state <= BLANK;
            end
            BLANK: begin
               if (vsync_fall) begin
                  row      <= '0;
                  row_base <= '0;
                  col      <= '0;
                  phase    <= 1'b0;
                  err      <= 1'b0;
                  state    <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (href_fall) begin
                  // Line end: odd byte count or wrong pixel count marks the frame.
                  if (phase || (col != H_LIM)) err <= 1'b1;
                  if (row < V_LIM)  row <= row + ROW_W'(1);
                  if (row < V_LAST) row_base <= row_base + H_STEP;
                  col   <= '0;
                  phase <= 1'b0;
               end else if (href_q && !vsync_rise) begin
                  if (!phase) begin
                     hi    <= {d_q[7:4], d_q[2:0]};
                     phase <= 1'b1;
                  end else begin
                     phase <= 1'b0;
                     if (pixel_ok) begin
                        wr_en   <= 1'b1;
                        wr_addr <= pix_addr;
                        wr_data <= {hi, d_q[7], d_q[4:1]};
                     end else begin
                        err <= 1'b1;
                     end
                     if (col < H_LIM) col <= col + COL_W'(1);
                  end
               end
               // Frame end; a line still in progress is abandoned.
               if (vsync_rise) begin
                  if (href_q) err <= 1'b1;
                  done   <= 1'b1;
                  frames <= frames + 8'd1;
                  state  <= BLANK;
               end
            end
            default: state <= SYNC;
         endcase
      end
   end
endmodule

// File: tb/tb_ov7670_frame_writer.sv
// Directed bench for ov7670_frame_writer on a 4x2 build.
module tb_ov7670_frame_writer;
   localparam int H  = 4;
   localparam int V  = 2;
   localparam int AW = 3;

   logic pclk = 1'b0;
   logic rst  = 1'b1;
   always #5 pclk = ~pclk;

   ov7670_frame_writer_if #(.ADDR_W(AW)) bus ();

   ov7670_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
      .pclk (pclk),
      .rst  (rst),
      .bus  (bus)
   );

   typedef struct {
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [11:0] exp_dout;
   } vec_t;

   vec_t vecs[8];

   int checks = 0;
   int errors = 0;

   // Write/pulse logger, sampled on the falling edge.
   logic [AW-1:0] log_addr[$];
   logic [11:0]   log_data[$];
   int done_cnt = 0;
   int max_addr = 0;
   always @(negedge pclk) begin
      if (!rst) begin
         if (bus.we === 1'b1) begin
            log_addr.push_back(bus.addr);
            log_data.push_back(bus.dout);
            if (int'(bus.addr) > max_addr) max_addr = int'(bus.addr);
         end
         if (bus.frame_done === 1'b1) done_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.href = 1'b1;
      bus.d    = b;
      tick(1);
   endtask

   task automatic end_line();
      bus.href = 1'b0;
      bus.d    = 8'd0;
      tick(3);
   endtask

   task automatic send_line(input int nbytes, input logic [7:0] seed);
      for (int i = 0; i < nbytes; i++) send_byte(8'(seed + 8'(i)));
      end_line();
   endtask

   task automatic frame_open();
      bus.vsync = 1'b0;
      tick(3);
   endtask

   task automatic frame_close();
      bus.vsync = 1'b1;
      tick(4);
   endtask

   task automatic clean_frame();
      frame_open();
      send_line(2 * H, 8'h20);
      send_line(2 * H, 8'h30);
      frame_close();
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " addr"},       32'(bus.addr), 0);
      check({tag, " dout"},       32'(bus.dout), 0);
      check({tag, " we"},         32'(bus.we), 0);
      check({tag, " frame_done"}, 32'(bus.frame_done), 0);
      check({tag, " line_err"},   32'(bus.line_err), 0);
      check({tag, " frame_cnt"},  32'(bus.frame_cnt), 0);
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int done_base;
      int n;

      vecs[0] = '{8'hF8, 8'h1F, 12'hF0F};
      vecs[1] = '{8'h07, 8'hE0, 12'h0F0};
      vecs[2] = '{8'h00, 8'h00, 12'h000};
      vecs[3] = '{8'hFF, 8'hFF, 12'hFFF};
      vecs[4] = '{8'h12, 8'h34, 12'h14A};
      vecs[5] = '{8'hA5, 8'h5A, 12'hAAD};
      vecs[6] = '{8'h80, 8'h01, 12'h800};
      vecs[7] = '{8'h04, 8'h80, 12'h090};

      bus.vsync = 1'b0;
      bus.href  = 1'b0;
      bus.d     = 8'd0;
      rst       = 1'b1;
      tick(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      tick(2);
      done_base = done_cnt;

      // Leave SYNC via a vsync high period.
      bus.vsync = 1'b1;
      tick(3);

      // Frame A: table-driven pixels, 2 lines of 4.
      clear_log();
      frame_open();
      for (int i = 0; i < 8; i++) begin
         send_byte(vecs[i].b0);
         send_byte(vecs[i].b1);
         if ((i % H) == H - 1) end_line();
      end
      frame_close();
      check("A write count", log_addr.size(), 8);
      n = (log_addr.size() < 8) ? log_addr.size() : 8;
      for (int i = 0; i < n; i++) begin
         $display("vec %0d: bytes %02h %02h -> addr %0d dout %03h (want addr %0d dout %03h)",
                  i, vecs[i].b0, vecs[i].b1, log_addr[i], log_data[i], i, vecs[i].exp_dout);
         check($sformatf("A addr[%0d]", i), 32'(log_addr[i]), i);
         check($sformatf("A dout[%0d]", i), 32'(log_data[i]), 32'(vecs[i].exp_dout));
      end
      check("A frame_done pulses", done_cnt - done_base, 1);
      check("A frame_cnt", 32'(bus.frame_cnt), 1);
      check("A line_err", 32'(bus.line_err), 0);

      // Bytes during blanking are never written.
      clear_log();
      send_line(2 * H, 8'h40);
      check("blank writes", log_addr.size(), 0);

      // Frame B: odd-length first line, then latency checks on line 2.
      clear_log();
      frame_open();
      send_line(2 * H + 1, 8'h10);
      send_byte(8'hF8);
      send_byte(8'h1F);
      check("lat we before", 32'(bus.we), 0);
      send_byte(8'h07);
      check("lat we after 2", 32'(bus.we), 1);
      check("lat dout F0F", 32'(bus.dout), 32'h0F0F);
      check("lat addr row1", 32'(bus.addr), 4);
      send_byte(8'hE0);
      check("lat we one cycle", 32'(bus.we), 0);
      send_byte(8'h00);
      check("lat dout 0F0", 32'(bus.dout), 32'h00F0);
      check("lat addr next", 32'(bus.addr), 5);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      end_line();
      frame_close();
      $display("frame B: %0d writes, line_err %0d", log_addr.size(), bus.line_err);
      check("B write count", log_addr.size(), 8);
      if (log_addr.size() > 4) check("B line2 start addr", 32'(log_addr[4]), 4);
      check("B line_err", 32'(bus.line_err), 1);
      check("B frame_cnt", 32'(bus.frame_cnt), 2);

      // Frame C: overlong line and a line past V_ACTIVE.
      clear_log();
      frame_open();
      send_line(2 * H + 4, 8'h50);
      send_line(2 * H, 8'h60);
      send_line(2 * H, 8'h70);
      frame_close();
      $display("frame C: %0d writes, line_err %0d", log_addr.size(), bus.line_err);
      check("C write count", log_addr.size(), 8);
      if (log_addr.size() > 0) check("C last addr", 32'(log_addr[log_addr.size() - 1]), 7);
      check("C line_err", 32'(bus.line_err), 1);
      check("C frame_cnt", 32'(bus.frame_cnt), 3);

      // Frame D: clean frame clears the sticky error.
      clean_frame();
      check("D line_err", 32'(bus.line_err), 0);
      check("D frame_cnt", 32'(bus.frame_cnt), 4);
      check("D frame_done pulses", done_cnt - done_base, 4);

      // Reset mid-line, released mid-frame.
      frame_open();
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      rst = 1'b1;
      tick(1);
      check_reset_outputs("midreset");
      rst = 1'b0;
      tick(1);
      done_base = done_cnt;
      clear_log();
      send_byte(8'h44);
      send_byte(8'h55);
      send_byte(8'h66);
      send_byte(8'h77);
      send_byte(8'h88);
      end_line();
      send_line(2 * H, 8'h90);
      frame_close();
      $display("after reset: %0d writes, frame_cnt %0d", log_addr.size(), bus.frame_cnt);
      check("rst frame writes", log_addr.size(), 0);
      check("rst frame_cnt", 32'(bus.frame_cnt), 0);
      check("rst frame_done", done_cnt - done_base, 0);
      clean_frame();
      check("post rst writes", log_addr.size(), 8);
      check("post rst frame_cnt", 32'(bus.frame_cnt), 1);
      check("post rst frame_done", done_cnt - done_base, 1);

      // Frame F: vsync rises while href is still high.
      frame_open();
      send_line(2 * H, 8'hA0);
      for (int i = 0; i < 4; i++) send_byte(8'(8'hB0 + 8'(i)));
      bus.vsync = 1'b1;
      bus.href  = 1'b1;
      bus.d     = 8'hC5;
      tick(1);
      bus.href  = 1'b0;
      tick(4);
      check("F frame_done", done_cnt - done_base, 2);
      check("F frame_cnt", 32'(bus.frame_cnt), 2);
      check("F line_err", 32'(bus.line_err), 1);

      // Run to 256 frames since reset release: counter wraps to zero.
      for (int f = 0; f < 254; f++) clean_frame();
      $display("wrap: frame_cnt %0d, pulses %0d, max addr %0d", bus.frame_cnt, done_cnt - done_base, max_addr);
      check("wrap frame_cnt", 32'(bus.frame_cnt), 0);
      check("wrap frame_done", done_cnt - done_base, 256);
      check("wrap line_err", 32'(bus.line_err), 0);
      check("max addr", max_addr, 7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
